// File: rtl/cordic_arbiter.sv
// Round-robin front end for a shared, non-stallable CORDIC pipeline.
// Credits reserve a result-FIFO slot for every issued job, so the return path never needs back-pressure.

module cordic_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    empty, full, do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;

  assign valid = ~empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module cordic_arbiter #(
  parameter int UNSIGNED_INPUT_WIDTH  = 16,
  parameter int UNSIGNED_OUTPUT_WIDTH = 16,
  parameter int SECTOR_FLAG_WIDTH     = 2,
  parameter int PIPE_LATENCY          = 8,
  parameter int RES_DEPTH             = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [UNSIGNED_INPUT_WIDTH-1:0]  a_degree,
  input  logic [UNSIGNED_INPUT_WIDTH-1:0]  a_x,
  input  logic [UNSIGNED_INPUT_WIDTH-1:0]  a_y,
  input  logic [SECTOR_FLAG_WIDTH-1:0]     a_sector,
  input  logic                             b_valid,
  output logic                             b_ready,
  input  logic [UNSIGNED_INPUT_WIDTH-1:0]  b_x,
  input  logic [UNSIGNED_INPUT_WIDTH-1:0]  b_y,
  input  logic [SECTOR_FLAG_WIDTH-1:0]     b_sector,
  output logic [UNSIGNED_INPUT_WIDTH-1:0]  pipe_degree_in,
  output logic [UNSIGNED_INPUT_WIDTH-1:0]  pipe_x_in,
  output logic [UNSIGNED_INPUT_WIDTH-1:0]  pipe_y_in,
  output logic [SECTOR_FLAG_WIDTH-1:0]     pipe_sector_in,
  output logic                             pipe_arctan_en_in,
  output logic                             pipe_valid_in,
  input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] pipe_degree_out,
  input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] pipe_x_out,
  input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] pipe_y_out,
  input  logic [SECTOR_FLAG_WIDTH-1:0]     pipe_sector_out,
  input  logic                             pipe_arctan_en_out,
  input  logic                             pipe_valid_out,
  output logic                             a_res_valid,
  input  logic                             a_res_ready,
  output logic [UNSIGNED_OUTPUT_WIDTH-1:0] a_res_x,
  output logic [UNSIGNED_OUTPUT_WIDTH-1:0] a_res_y,
  output logic [SECTOR_FLAG_WIDTH-1:0]     a_res_sector,
  output logic                             b_res_valid,
  input  logic                             b_res_ready,
  output logic [UNSIGNED_OUTPUT_WIDTH-1:0] b_res_degree,
  output logic [SECTOR_FLAG_WIDTH-1:0]     b_res_sector,
  output logic                             err
);
  localparam int OW = UNSIGNED_OUTPUT_WIDTH;
  localparam int SW = SECTOR_FLAG_WIDTH;
  localparam int CW = $clog2(RES_DEPTH) + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(RES_DEPTH);
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  typedef struct packed {
    logic [OW-1:0] x;
    logic [OW-1:0] y;
    logic [SW-1:0] sector;
  } a_res_t;

  typedef struct packed {
    logic [OW-1:0] degree;
    logic [SW-1:0] sector;
  } b_res_t;

  logic [CW-1:0] cred_a, cred_b;
  logic          last;
  logic          pop_a, pop_b, elig_a, elig_b, acc_a, acc_b;
  logic          push_a, push_b, ovf_a, ovf_b;
  a_res_t        a_din, a_dout;
  b_res_t        b_din, b_dout;

  assign pop_a = a_res_valid & a_res_ready;
  assign pop_b = b_res_valid & b_res_ready;

  // A pop this cycle releases a slot, so a requester at its credit limit may reuse it immediately.
  assign elig_a = a_valid & ((cred_a < CRED_MAX) | pop_a);
  assign elig_b = b_valid & ((cred_b < CRED_MAX) | pop_b);

  assign a_ready = elig_a & (~elig_b | (last == LAST_B));
  assign b_ready = elig_b & (~elig_a | (last == LAST_A));
  assign acc_a   = a_ready;
  assign acc_b   = b_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last   <= LAST_B;
      cred_a <= '0;
      cred_b <= '0;
    end else begin
      if (acc_a)      last <= LAST_A;
      else if (acc_b) last <= LAST_B;
      case ({acc_a, pop_a})
        2'b10:   cred_a <= cred_a + 1'b1;
        2'b01:   cred_a <= cred_a - 1'b1;
        default: cred_a <= cred_a;
      endcase
      case ({acc_b, pop_b})
        2'b10:   cred_b <= cred_b + 1'b1;
        2'b01:   cred_b <= cred_b - 1'b1;
        default: cred_b <= cred_b;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid_in     <= 1'b0;
      pipe_degree_in    <= '0;
      pipe_x_in         <= '0;
      pipe_y_in         <= '0;
      pipe_sector_in    <= '0;
      pipe_arctan_en_in <= 1'b0;
    end else begin
      pipe_valid_in <= acc_a | acc_b;
      if (acc_a) begin
        pipe_degree_in    <= a_degree;
        pipe_x_in         <= a_x;
        pipe_y_in         <= a_y;
        pipe_sector_in    <= a_sector;
        pipe_arctan_en_in <= 1'b0;
      end else if (acc_b) begin
        pipe_degree_in    <= '0;
        pipe_x_in         <= b_x;
        pipe_y_in         <= b_y;
        pipe_sector_in    <= b_sector;
        pipe_arctan_en_in <= 1'b1;
      end
    end
  end

  assign push_a = pipe_valid_out & ~pipe_arctan_en_out;
  assign push_b = pipe_valid_out &  pipe_arctan_en_out;
  assign a_din  = '{x: pipe_x_out, y: pipe_y_out, sector: pipe_sector_out};
  assign b_din  = '{degree: pipe_degree_out, sector: pipe_sector_out};

  cordic_res_fifo #(.W($bits(a_res_t)), .DEPTH(RES_DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .push(push_a), .din(a_din), .pop(a_res_ready),
    .dout(a_dout), .valid(a_res_valid), .ovf(ovf_a)
  );

  cordic_res_fifo #(.W($bits(b_res_t)), .DEPTH(RES_DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .push(push_b), .din(b_din), .pop(b_res_ready),
    .dout(b_dout), .valid(b_res_valid), .ovf(ovf_b)
  );

  assign a_res_x      = a_dout.x;
  assign a_res_y      = a_dout.y;
  assign a_res_sector = a_dout.sector;
  assign b_res_degree = b_dout.degree;
  assign b_res_sector = b_dout.sector;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                err <= 1'b0;
    else if (ovf_a | ovf_b)  err <= 1'b1;
  end
endmodule
